bpu_pht: RTL and testbench

- Pattern history table for the branch prediction unit: an array of 2-bit saturating counters indexed by fetch PC, optionally hashed with a global history register (gshare).
- Lookup port serves the fetch stage with a registered taken/not-taken prediction.
- Update port takes resolved branch outcomes from EX and trains the counter that made the prediction.
- The fetch pipeline carries out_pred_Index down to EX and returns it on in_upd_Index, so an update always trains the entry used for the prediction.

---
 rtl/bpu_pht.sv | 84 ++++++++
 tb/tb_bpu_pht.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bpu_pht.sv
// Branch pattern history table: 2-bit saturating counters, registered lookup.
// Define BPU_GSHARE_EN to hash the index with a non-speculative global history.
module bpu_pht #(
  parameter int INDEX_W = 6,
  parameter int HIST_W  = 6
) (
  input  logic               in_Clk,
  input  logic               in_Rst,
  input  logic               in_pred_En,
  input  logic [63:0]        in_pred_PC,
  output logic               out_pred_Valid,
  output logic               out_pred_Taken,
  output logic [INDEX_W-1:0] out_pred_Index,
  input  logic               in_upd_En,
  input  logic [INDEX_W-1:0] in_upd_Index,
  input  logic               in_upd_Taken,
  output logic [HIST_W-1:0]  out_GHR
);

  localparam int N = 1 << INDEX_W;

  logic [1:0]         cnt_q [N];
  logic [INDEX_W-1:0] pred_idx;
  logic [1:0]         upd_cur;
  logic [1:0]         upd_nxt;
  logic               unused_pc;

  assign unused_pc = ^{in_pred_PC[63:INDEX_W+2], in_pred_PC[1:0]};

`ifdef BPU_GSHARE_EN
  logic [HIST_W-1:0] ghr_q;

  assign pred_idx = in_pred_PC[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
  assign out_GHR  = ghr_q;

  // History shifts in resolved outcomes only, newest at bit 0.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      ghr_q <= '0;
    end else if (in_upd_En) begin
      ghr_q <= HIST_W'({ghr_q, in_upd_Taken});
    end
  end
`else
  assign pred_idx = in_pred_PC[INDEX_W+1:2];
  assign out_GHR  = '0;
`endif

  // Saturating step of the counter being trained.
  always_comb begin
    upd_cur = cnt_q[in_upd_Index];
    upd_nxt = upd_cur;
    if (in_upd_Taken) begin
      if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
    end
  end

  // Counter table: reset to weakly not-taken, train one entry per update.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= 2'b01;
    end else if (in_upd_En) begin
      cnt_q[in_upd_Index] <= upd_nxt;
    end
  end

  // Registered lookup reads the pre-update table and history.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      out_pred_Valid <= 1'b0;
      out_pred_Taken <= 1'b0;
      out_pred_Index <= '0;
    end else if (in_pred_En) begin
      out_pred_Valid <= 1'b1;
      out_pred_Taken <= cnt_q[pred_idx][1];
      out_pred_Index <= pred_idx;
    end else begin
      out_pred_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bpu_pht.sv
// Self-checking bench for bpu_pht with a reference model and scoreboard.
// Works with or without BPU_GSHARE_EN.
module tb_bpu_pht;

  logic        in_Clk = 0;
  logic        in_Rst = 0;
  logic        in_pred_En = 0;
  logic [63:0] in_pred_PC = '0;
  logic        out_pred_Valid;
  logic        out_pred_Taken;
  logic [5:0]  out_pred_Index;
  logic        in_upd_En = 0;
  logic [5:0]  in_upd_Index = '0;
  logic        in_upd_Taken = 0;
  logic [5:0]  out_GHR;

  bpu_pht #(.INDEX_W(6), .HIST_W(6)) dut (
    .in_Clk(in_Clk),
    .in_Rst(in_Rst),
    .in_pred_En(in_pred_En),
    .in_pred_PC(in_pred_PC),
    .out_pred_Valid(out_pred_Valid),
    .out_pred_Taken(out_pred_Taken),
    .out_pred_Index(out_pred_Index),
    .in_upd_En(in_upd_En),
    .in_upd_Index(in_upd_Index),
    .in_upd_Taken(in_upd_Taken),
    .out_GHR(out_GHR)
  );

  always #5 in_Clk = ~in_Clk;

  logic [13:0] obs;
  assign obs = {out_pred_Valid, out_pred_Taken, out_pred_Index, out_GHR};

  logic [1:0]  mcnt [64];
  logic [5:0]  mghr = 0;
  logic        mv = 0, mt = 0;
  logic [5:0]  mi = 0;
  logic [13:0] sb [$];
  logic [13:0] e;
  int          total = 0;
  int          passed = 0;

  function automatic logic [63:0] pc_for(input logic [5:0] idx);
`ifdef BPU_GSHARE_EN
    return 64'(idx ^ mghr) << 2;
`else
    return 64'(idx) << 2;
`endif
  endfunction

  // Drive one cycle, push the model's expectation, advance to next negedge.
  task automatic drive(input logic rst, input logic pe,
                       input logic [63:0] pc, input logic ue,
                       input logic [5:0] ui, input logic ut);
    logic [5:0] idx;
    in_Rst = rst; in_pred_En = pe; in_pred_PC = pc;
    in_upd_En = ue; in_upd_Index = ui; in_upd_Taken = ut;
`ifdef BPU_GSHARE_EN
    idx = pc[7:2] ^ mghr;
`else
    idx = pc[7:2];
`endif
    if (rst) begin
      for (int i = 0; i < 64; i++) mcnt[i] = 2'b01;
      mghr = 0; mv = 0; mt = 0; mi = 0;
    end else begin
      if (pe) begin mv = 1; mt = mcnt[idx][1]; mi = idx; end
      else mv = 0;
      if (ue) begin
        if (ut) mcnt[ui] = (mcnt[ui] == 2'b11) ? 2'b11 : 2'(mcnt[ui] + 1);
        else    mcnt[ui] = (mcnt[ui] == 2'b00) ? 2'b00 : 2'(mcnt[ui] - 1);
`ifdef BPU_GSHARE_EN
        mghr = {mghr[4:0], ut};
`endif
      end
    end
    sb.push_back({mv, mt, mi, mghr});
    @(posedge in_Clk);
    @(negedge in_Clk);
    in_Rst = 0; in_pred_En = 0; in_upd_En = 0;
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs !== e || obs !== 14'd0) $display("FAIL reset: got %h want %h", obs, e);
    else passed++;
    drive(0, 1, 64'h100, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs !== e || obs !== {1'b1, 1'b0, 6'd0, 6'd0})
      $display("FAIL first_lookup: got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_update;
    drive(1, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 1, 6'd5, 1);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL upd_%0d: got %h want %h", k, obs, e);
      else passed++;
    end
    total++;
`ifdef BPU_GSHARE_EN
    if (out_GHR !== 6'h03) $display("FAIL ghr_after_upd: got %h want 03", out_GHR);
    else passed++;
    drive(0, 1, 64'h18, 0, 0, 0);
`else
    if (out_GHR !== 6'h00) $display("FAIL ghr_after_upd: got %h want 00", out_GHR);
    else passed++;
    drive(0, 1, 64'h14, 0, 0, 0);
`endif
    e = sb.pop_front(); total++;
    if (obs !== e || out_pred_Index !== 6'd5 || out_pred_Taken !== 1'b1)
      $display("FAIL trained_lookup: got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_saturate;
    drive(1, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 6'd9, 1);
      void'(sb.pop_front());
    end
    drive(0, 0, 0, 1, 6'd9, 0);
    void'(sb.pop_front());
    drive(0, 1, pc_for(6'd9), 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs !== e || out_pred_Taken !== 1'b1 || out_pred_Index !== 6'd9)
      $display("FAIL sat_high: got %h want %h", obs, e);
    else passed++;
    drive(1, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 6'd9, 0);
      void'(sb.pop_front());
    end
    drive(0, 0, 0, 1, 6'd9, 1);
    void'(sb.pop_front());
    drive(0, 1, pc_for(6'd9), 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs !== e || out_pred_Taken !== 1'b0 || out_pred_Index !== 6'd9)
      $display("FAIL sat_low: got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_collision;
    drive(1, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(0, 1, pc_for(6'd5), 1, 6'd5, 1);
    e = sb.pop_front(); total++;
    if (obs !== e || out_pred_Taken !== 1'b0 || out_pred_Index !== 6'd5)
      $display("FAIL collide_old: got %h want %h", obs, e);
    else passed++;
    drive(0, 1, pc_for(6'd5), 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs !== e || out_pred_Taken !== 1'b1 || out_pred_Index !== 6'd5)
      $display("FAIL collide_new: got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_stall;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 64'hdead_beef, 0, 0, 0);
      e = sb.pop_front(); total++;
      if (obs !== e || out_pred_Valid !== 1'b0 || out_pred_Taken !== 1'b1 ||
          out_pred_Index !== 6'd5)
        $display("FAIL stall_%0d: got %h want %h", k, obs, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 0, 1, 6'd5, 1);
    void'(sb.pop_front());
    drive(1, 1, pc_for(6'd5), 1, 6'd5, 1);
    e = sb.pop_front(); total++;
    if (obs !== e || obs !== 14'd0) $display("FAIL reset_mid: got %h want %h", obs, e);
    else passed++;
    drive(0, 1, pc_for(6'd5), 0, 0, 0);
    e = sb.pop_front(); total++;
    if (obs !== e || out_pred_Taken !== 1'b0 || out_pred_Index !== 6'd5)
      $display("FAIL reset_mid_cnt: got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 49) == 0, 1'($urandom), {$urandom, $urandom},
            1'($urandom), 6'($urandom_range(0, 63)), 1'($urandom));
      e = sb.pop_front(); total++;
      if (obs !== e) begin
        if (bad < 10) $display("FAIL random_%0d: got %h want %h", k, obs, e);
        bad++;
      end else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mcnt[i] = 2'b01;
    @(negedge in_Clk);
    test_reset;
    test_update;
    test_saturate;
    test_collision;
    test_stall;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
